// File: rtl/gpio_uart_tx.sv
// GPIO byte capture FIFO feeding a UART transmitter (8N1, LSB first).
// Optional even-parity bit (8E1) when GPIO_UART_PARITY_EN is defined.
module gpio_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  gpio_in,
  input  logic                        gpio_en,
  output logic                        tx,
  output logic                        busy,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef GPIO_UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state, next_state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [15:0]   baud;
  logic          baud_end;
  logic          pop;
  logic          push;
`ifdef GPIO_UART_PARITY_EN
  logic          par;
`endif

  assign baud_end  = (baud == BAUD_LAST);
  assign fifo_full = (fifo_count == FULL_COUNT);
  // A pop in the same edge frees a slot, so a full FIFO can still accept.
  assign push      = gpio_en && (!fifo_full || pop);

  always_comb begin
    next_state = state;
    tx         = 1'b1;
    busy       = 1'b1;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (fifo_count != '0) begin
          pop        = 1'b1;
          next_state = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (baud_end) next_state = DATA;
      end
      DATA: begin
        tx = shift[0];
        if (baud_end && bit_idx == 3'd7) begin
`ifdef GPIO_UART_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef GPIO_UART_PARITY_EN
      PARITY: begin
        tx = par;
        if (baud_end) next_state = STOP;
      end
`endif
      STOP: begin
        if (baud_end) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      baud    <= '0;
`ifdef GPIO_UART_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if (pop) begin
        shift   <= mem[rd_ptr];
        bit_idx <= '0;
        baud    <= '0;
`ifdef GPIO_UART_PARITY_EN
        par     <= ^mem[rd_ptr];
`endif
      end else if (state != IDLE) begin
        if (baud_end) begin
          baud <= '0;
          if (state == DATA) begin
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end else begin
          baud <= baud + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= gpio_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
      if (gpio_en && fifo_full && !pop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gpio_uart_tx.sv
// Bench for gpio_uart_tx: frame-position model checked every cycle plus directed literal checks.
module tb_gpio_uart_tx;
  localparam int C = 4;
  localparam int D = 4;
`ifdef GPIO_UART_PARITY_EN
  localparam int FL = 11 * C;
`else
  localparam int FL = 10 * C;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       gpio_en = 1'b0;
  logic [7:0] gpio_in = 8'h00;
  logic       tx, busy, fifo_full, overflow;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  gpio_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .gpio_in(gpio_in), .gpio_en(gpio_en),
    .tx(tx), .busy(busy), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Model: queue of bytes, plus the position of the current frame in clock cycles.
  logic [7:0] mq[$];
  bit         m_act = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_ovf = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_act = 1'b0;
      m_pos = 0;
      m_ovf = 1'b0;
    end else begin
      if (m_act) begin
        m_pos++;
        if (m_pos == FL) m_act = 1'b0;
      end else if (mq.size() > 0) begin
        m_byte = mq.pop_front();
        m_act  = 1'b1;
        m_pos  = 0;
      end
      if (gpio_en) begin
        if (mq.size() < D) mq.push_back(gpio_in);
        else m_ovf = 1'b1;
      end
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!m_act) return 1'b1;
    k = m_pos / C;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
`ifdef GPIO_UART_PARITY_EN
    if (k == 9) return ^m_byte;
`endif
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_tx", tx, exp_tx());
      check("model_busy", busy, m_act);
      check("model_count", fifo_count, mq.size());
      check("model_full", fifo_full, mq.size() == D);
      check("model_overflow", overflow, m_ovf);
    end
  end

  task automatic wait_idle(input int max, input string name);
    int t = 0;
    while (busy !== 1'b0 && t < max) begin
      @(negedge clk);
      t++;
    end
    if (t >= max) timeout(name);
  endtask

  // Line receiver: samples mid-bit, returns at the middle of the stop bit.
  task automatic rx_byte(output logic [7:0] b, output bit ok);
    int t = 0;
    b  = 8'h00;
    ok = 1'b0;
    while (tx !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      timeout("rx_start");
      return;
    end
    repeat (C / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(negedge clk);
      b[i] = tx;
    end
`ifdef GPIO_UART_PARITY_EN
    repeat (C) @(negedge clk);
    check("rx_parity", tx, ^b);
`endif
    repeat (C) @(negedge clk);
    ok = (tx === 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    bit          ok;
    int          t;
    bit          seen_idle;
    logic [0:10] a5_bits;
`ifdef GPIO_UART_PARITY_EN
    a5_bits = 11'b01010010101;
`else
    a5_bits = 11'b01010010111;
`endif

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_on = 1'b1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_full", fifo_full, 0);
    check("rst_overflow", overflow, 0);

    // Single byte 0xA5
    gpio_in = 8'hA5; gpio_en = 1'b1;
    @(negedge clk);
    gpio_en = 1'b0;
    check("a5_count_after_push", fifo_count, 1);
    check("a5_tx_still_idle", tx, 1);
    @(negedge clk);
    check("a5_tx_start", tx, 0);
    t = 0;
    while (busy === 1'b1 && t < 200) begin
      if (t % C == C / 2) check("a5_bit", tx, a5_bits[t / C]);
      t++;
      @(negedge clk);
    end
    check("a5_busy_len", t, FL);

    // Back-to-back 0x01, 0x80
    @(negedge clk);
    gpio_in = 8'h01; gpio_en = 1'b1;
    @(negedge clk);
    check("b2b_count_e0", fifo_count, 1);
    gpio_in = 8'h80;
    @(negedge clk);
    gpio_en = 1'b0;
    check("b2b_count_e1", fifo_count, 1);
    check("b2b_first_start", tx, 0);
    t = 0;
    seen_idle = 1'b0;
    while (!(seen_idle && tx === 1'b0) && t < 200) begin
      @(negedge clk);
      t++;
      if (busy === 1'b0) seen_idle = 1'b1;
    end
    check("b2b_start_spacing", t, FL + 1);
    check("b2b_count_after_2nd_pop", fifo_count, 0);
    wait_idle(200, "b2b_drain");

    // Overflow: six consecutive pushes while idle
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          gpio_in = 8'h10 + 8'(i); gpio_en = 1'b1;
          @(negedge clk);
        end
        gpio_en = 1'b0;
        check("ovf_full", fifo_full, 1);
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
      end
      begin : rx_thr
        logic [7:0] rb;
        bit rok;
        for (int i = 0; i < 5; i++) begin
          rx_byte(rb, rok);
          check("ovf_rx_byte", rb, 8'h10 + 8'(i));
          check("ovf_rx_stop", rok, 1);
        end
      end
    join
    wait_idle(200, "ovf_drain");
    repeat (FL) @(negedge clk);
    check("ovf_no_extra_frame", busy, 0);
    check("ovf_sticky", overflow, 1);

    // Push into a full FIFO at the same edge as a pop
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_clears_overflow", overflow, 0);
    for (int i = 0; i < 5; i++) begin
      gpio_in = 8'h20 + 8'(i); gpio_en = 1'b1;
      @(negedge clk);
    end
    gpio_en = 1'b0;
    check("pp_full_before", fifo_full, 1);
    wait_idle(200, "pp_wait_idle");
    gpio_in = 8'h25; gpio_en = 1'b1;
    @(negedge clk);
    gpio_en = 1'b0;
    check("pp_count", fifo_count, 4);
    check("pp_full", fifo_full, 1);
    check("pp_no_overflow", overflow, 0);
    check("pp_busy", busy, 1);
    t = 0;
    while (!(busy === 1'b0 && fifo_count === 3'd0) && t < 6 * FL + 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 6 * FL + 50) timeout("pp_drain");

    // Reset in the middle of data bit 3
    @(negedge clk);
    gpio_in = 8'h5A; gpio_en = 1'b1;
    @(negedge clk);
    gpio_in = 8'h3C;
    @(negedge clk);
    gpio_en = 1'b0;
    check("mid_start", tx, 0);
    repeat (4 * C + 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_tx", tx, 1);
    check("mid_busy", busy, 0);
    check("mid_count", fifo_count, 0);
    check("mid_overflow", overflow, 0);
    t = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) t++;
    end
    check("mid_no_more_frames", t, 0);

    // Pointer wrap: ten spaced pushes
    for (int i = 0; i < 10; i++) begin
      gpio_in = 8'h30 + 8'(i); gpio_en = 1'b1;
      @(negedge clk);
      gpio_en = 1'b0;
      rx_byte(b, ok);
      check("wrap_rx_byte", b, 8'h30 + 8'(i));
      check("wrap_rx_stop", ok, 1);
    end
    wait_idle(200, "wrap_drain");
    check("wrap_no_overflow", overflow, 0);
    check("wrap_count", fifo_count, 0);

    repeat (2) @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
